// File: rtl/hc4_ram_arbiter_if.sv
// Bundle of core port, host port and RAM-macro signals around hc4_ram_arbiter.
// slave: the arbiter's view; master: the surrounding core/host/RAM environment.
interface hc4_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 4
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_ack;
    logic [DATA_W-1:0] c_rdata;

    logic              h_req;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_ack;
    logic [DATA_W-1:0] h_rdata;
    logic              h_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_ack, c_rdata,
        input  h_req, h_we, h_addr, h_wdata,
        output h_ack, h_rdata, h_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_ack, c_rdata,
        output h_req, h_we, h_addr, h_wdata,
        input  h_ack, h_rdata, h_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/hc4_ram_arbiter.sv
// Core/host arbiter for the HC4 256x4 data RAM: core priority, host starvation guard.
// Define HC4_ARB_WRITE_PROTECT_EN to block host writes into page PROT_PAGE (h_err reports it).
module hc4_ram_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned MAX_WAIT = 7,
    parameter int unsigned WAIT_W   = 4
`ifdef HC4_ARB_WRITE_PROTECT_EN
    ,
    parameter logic [3:0]  PROT_PAGE = 4'hF
`endif
) (
    input  logic             clk,
    input  logic             nReset,
    hc4_ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;     // 1: host owns the current access
    logic              we_q, we_d;
    logic              blocked_q, blocked_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              host_wins;
    logic              host_blocked;
    logic [DATA_W-1:0] resp_data;
    logic              in_resp;
    logic              in_access;

`ifdef HC4_ARB_WRITE_PROTECT_EN
    assign host_blocked = bus.h_we && (bus.h_addr[ADDR_W-1 -: 4] == PROT_PAGE);
`else
    assign host_blocked = 1'b0;
`endif

    assign host_wins = bus.h_req && ((wait_q == WAIT_W'(MAX_WAIT)) || !bus.c_req);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        blocked_d = blocked_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        unique case (state_q)
            StIdle: begin
                if (host_wins) begin
                    state_d   = StAccess;
                    owner_d   = 1'b1;
                    we_d      = bus.h_we;
                    blocked_d = host_blocked;
                    addr_d    = bus.h_addr;
                    wdata_d   = bus.h_wdata;
                    wait_d    = '0;
                end else if (bus.c_req) begin
                    state_d   = StAccess;
                    owner_d   = 1'b0;
                    we_d      = bus.c_we;
                    blocked_d = 1'b0;
                    addr_d    = bus.c_addr;
                    wdata_d   = bus.c_wdata;
                    // A waiting host losing here implies wait_q < MAX_WAIT, so no overflow.
                    wait_d    = bus.h_req ? wait_q + 1'b1 : '0;
                end else begin
                    wait_d    = '0;
                end
            end
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            blocked_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            blocked_q <= blocked_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
        end
    end

    // Outputs decode straight from state so reset silences them without waiting for a clock.
    assign in_access = (state_q == StAccess);
    assign in_resp   = (state_q == StResp);
    assign resp_data = we_q ? wdata_q : bus.mem_rdata;

    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access && we_q && !blocked_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.c_ack   = in_resp && !owner_q;
    assign bus.h_ack   = in_resp && owner_q;
    assign bus.h_err   = in_resp && owner_q && blocked_q;
    assign bus.c_rdata = (in_resp && !owner_q) ? resp_data : '0;
    assign bus.h_rdata = (in_resp && owner_q) ? resp_data : '0;

    assign bus.busy = (state_q != StIdle);

endmodule
